bird_wave_ctrl: RTL and testbench
=================================

Name: bird_wave_ctrl

Overview:
- Parametrised wave scheduler for the bird enemies.
- Decides when, which and how many birds to deploy, and sets their speed and starting life.
- Escalates difficulty per wave and tracks wave clearance from the per-bird alive flags.
- Sits beside the bird top level: drives its deploy_bird, bird_speed and bird_life inputs and consumes its bird_alive outputs.

Parameters:
- NUM_OF_BIRDS, 4, number of bird slots (1..16).
- NUM_WAVES, 8, waves per game; clearing the last wave ends the game.
- BASE_BIRDS, 1, birds in wave 0; wave w deploys min(NUM_OF_BIRDS, BASE_BIRDS+w).
- BASE_LIFE, 2, starting life in wave 0; wave w uses min(15, BASE_LIFE+w).
- SPEED_STEP, 2, waves per speed increment; speed = min(3, w/SPEED_STEP).
- INTERMISSION_FRAMES, 60, frames between waves.
- SPAWN_GAP_MIN, 16, minimum frames between successive deploys.
- GAP_MASK, 8'h1F, mask applied to random_number to form the extra gap.
- ALIVE_TIMEOUT, 4, frames a deployed slot may stay not-alive before it counts as spawned-and-dead.

Ports:
- clk, in, 1, system clock.
- resetN, in, 1, asynchronous active-low reset.
- startOfFrame, in, 1, one-clock pulse per video frame.
- start_game, in, 1, one-clock pulse; starts or restarts a game.
- pause, in, 1, level; freezes all frame counters and the FSM.
- random_number, in, 8, free-running random value.
- bird_alive, in, NUM_OF_BIRDS, per-slot alive flags.
- deploy_bird, out, NUM_OF_BIRDS, one-clock one-hot deploy pulse.
- bird_speed, out, 2, speed for the current wave.
- bird_life, out, 4, starting life for the current wave.
- wave_number, out, $clog2(NUM_WAVES+1), current wave index.
- wave_active, out, 1, high in SPAWN and ACTIVE.
- birds_remaining, out, 5, birds still to deploy plus birds alive in this wave.
- game_won, out, 1, high in WIN.

Behaviour:
- Reset (asynchronous):
  - state=IDLE.
  - All outputs 0; wave_number=0.
  - All counters and masks cleared.
- Frame counters decrement only on startOfFrame with pause=0. All other logic is clocked every clk.
- States and transitions:
  - IDLE: waits for start_game, then goes to INTERMISSION with wave_number=0.
  - INTERMISSION: loads INTERMISSION_FRAMES on entry. At 0 it latches wave parameters (bird_speed, bird_life, wave_size) and goes to SPAWN with gap counter=0.
  - SPAWN: when the gap counter is 0, picks the lowest-index slot with bird_alive=0 and deployed_mask=0.
    - Asserts deploy_bird for exactly one clk and sets deployed_mask and pending for that slot.
    - Reloads gap = SPAWN_GAP_MIN + (random_number & GAP_MASK), sampled in the deploy cycle.
    - If no slot is free, retries every clk without reloading the gap.
    - When the deploy count reaches wave_size, goes to ACTIVE.
  - ACTIVE: goes to CLEARED when deployed_mask&bird_alive==0 and no pending bit is set.
  - CLEARED: lasts 1 clk.
    - Clears deployed_mask and increments wave_number.
    - Goes to WIN if wave_number+1==NUM_WAVES, otherwise to INTERMISSION.
  - WIN: game_won=1; holds until start_game.
- Pending bits:
  - A pending bit clears when its slot's bird_alive is seen high.
  - It also clears when its per-slot ALIVE_TIMEOUT frame counter expires. This prevents deadlock when a bird dies in the same frame it spawns.
- start_game in any state is an immediate restart:
  - wave_number=0, masks and counters cleared, state goes to INTERMISSION.
  - A deploy pulse is suppressed if it coincides with start_game.
- pause=1: no state transition, no deploy pulse, counters hold. bird_alive changes are still tracked in the pending bits.
- Outputs:
  - bird_speed and bird_life are registered and change only at the INTERMISSION to SPAWN transition. They are stable while any bird of the wave is deployed.
  - birds_remaining = (wave_size − deploys so far) + popcount(deployed_mask&bird_alive), registered with 1 clk latency.
- Saturation: speed saturates at 3, life at 15, and wave_size at NUM_OF_BIRDS.
- Gap arithmetic is done at 9 bits, so there is no wrap.

Decomposition:
- Package bird_pkg holds:
  - wave_state_t enum: IDLE, INTERMISSION, SPAWN, ACTIVE, CLEARED, WIN.
  - Constants MAX_SPEED=3 and MAX_LIFE=15.
  - A function computing the wave parameters from the wave index.
- Sub-module frame_timer: a loadable down-counter that decrements on startOfFrame&!pause and flags zero.
  - One instance serves intermission and spawn gap, since they are mutually exclusive.
  - NUM_OF_BIRDS instances serve the pending timeouts.

Test Plan:
- Reset, then start_game, then 60 frames → one deploy_bird pulse on bit 0; bird_speed=0, bird_life=2, wave_number=0.
- Wave 0: drive bird_alive[0]=1 for 10 frames then 0 → CLEARED; after 60 frames wave_number=1, and 2 deploys occur (bits 0 then 1) spaced ≥16 frames apart.
- bird_alive[0] held high (slot busy) during wave 2 spawn → deploys go to bits 1, 2, 3; wave waits for slot 0 to free.
- Deploy with bird_alive never rising → pending clears after 4 frames; wave advances.
- pause=1 for 100 frames mid-SPAWN → no deploy, counters frozen; resumes with the remaining gap.
- Clear all 8 waves → game_won=1, bird_speed=3, bird_life=9 in the last wave; start_game → wave_number=0, game_won=0.

Source files
------------

// File: rtl/bird_wave_ctrl_pkg.sv
// Shared types and helpers for the bird wave scheduler.
// Wave parameters are derived from the wave index with saturation.
package bird_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        INTERMISSION = 3'd1,
        SPAWN        = 3'd2,
        ACTIVE       = 3'd3,
        CLEARED      = 3'd4,
        WIN          = 3'd5
    } wave_state_t;

    localparam int unsigned MAX_SPEED = 3;
    localparam int unsigned MAX_LIFE  = 15;

    typedef struct packed {
        logic [1:0] speed;
        logic [3:0] life;
        logic [4:0] size;
    } wave_cfg_t;

    function automatic wave_cfg_t wave_cfg(input int unsigned wave,
                                           input int unsigned n_slots,
                                           input int unsigned base_birds,
                                           input int unsigned base_life,
                                           input int unsigned speed_step);
        wave_cfg_t   c;
        int unsigned spd;
        int unsigned lif;
        int unsigned siz;
        spd     = wave / speed_step;
        lif     = base_life + wave;
        siz     = base_birds + wave;
        c.speed = 2'((spd > MAX_SPEED) ? MAX_SPEED : spd);
        c.life  = 4'((lif > MAX_LIFE) ? MAX_LIFE : lif);
        c.size  = 5'((siz > n_slots) ? n_slots : siz);
        return c;
    endfunction

endpackage

// File: rtl/bird_wave_ctrl_frame_timer.sv
// Loadable frame down-counter; counts gated frame ticks and flags zero.
module frame_timer #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         tick_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bird_wave_ctrl.sv
// Wave scheduler for the bird enemies: deploys birds per wave, escalates
// difficulty and tracks wave clearance from the per-slot alive flags.
module bird_wave_ctrl
    import bird_pkg::*;
#(
    parameter int unsigned NUM_OF_BIRDS        = 4,
    parameter int unsigned NUM_WAVES           = 8,
    parameter int unsigned BASE_BIRDS          = 1,
    parameter int unsigned BASE_LIFE           = 2,
    parameter int unsigned SPEED_STEP          = 2,
    parameter int unsigned INTERMISSION_FRAMES = 60,
    parameter int unsigned SPAWN_GAP_MIN       = 16,
    parameter logic [7:0]  GAP_MASK            = 8'h1F,
    parameter int unsigned ALIVE_TIMEOUT       = 4
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic                             startOfFrame,
    input  logic                             start_game,
    input  logic                             pause,
    input  logic [7:0]                       random_number,
    input  logic [NUM_OF_BIRDS-1:0]          bird_alive,
    output logic [NUM_OF_BIRDS-1:0]          deploy_bird,
    output logic [1:0]                       bird_speed,
    output logic [3:0]                       bird_life,
    output logic [$clog2(NUM_WAVES+1)-1:0]   wave_number,
    output logic                             wave_active,
    output logic [4:0]                       birds_remaining,
    output logic                             game_won
);

    localparam int unsigned WN_W  = $clog2(NUM_WAVES + 1);
    localparam int unsigned TMO_W = (ALIVE_TIMEOUT < 2) ? 1 : $clog2(ALIVE_TIMEOUT + 1);

    wave_state_t             state_q, state_d;
    logic [WN_W-1:0]         wave_q, wave_d;
    logic [1:0]              speed_q, speed_d;
    logic [3:0]              life_q, life_d;
    logic [4:0]              size_q, size_d;
    logic [4:0]              deploys_q, deploys_d;
    logic [4:0]              remain_q, alive_cnt;
    logic [NUM_OF_BIRDS-1:0] mask_q, mask_d, pend_q, pend_d, deploy_q, deploy_d;
    logic [NUM_OF_BIRDS-1:0] pick, tmo_zero;
    logic                    found, tick, tmr_load, tmr_zero;
    logic [8:0]              tmr_val;
    wave_cfg_t               cfg;

    assign tick = startOfFrame & ~pause;
    assign cfg  = wave_cfg(32'(wave_q), NUM_OF_BIRDS, BASE_BIRDS, BASE_LIFE, SPEED_STEP);

    always_comb begin
        pick      = '0;
        found     = 1'b0;
        alive_cnt = '0;
        for (int unsigned i = 0; i < NUM_OF_BIRDS; i++) begin
            if (!found && !bird_alive[i] && !mask_q[i]) begin
                pick[i] = 1'b1;
                found   = 1'b1;
            end
            alive_cnt = alive_cnt + 5'(mask_q[i] & bird_alive[i]);
        end
    end

    always_comb begin
        state_d   = state_q;
        wave_d    = wave_q;
        speed_d   = speed_q;
        life_d    = life_q;
        size_d    = size_q;
        deploys_d = deploys_q;
        mask_d    = mask_q;
        deploy_d  = '0;
        tmr_load  = 1'b0;
        tmr_val   = 9'(INTERMISSION_FRAMES);
        if (start_game) begin
            state_d   = INTERMISSION;
            wave_d    = '0;
            size_d    = '0;
            deploys_d = '0;
            mask_d    = '0;
            tmr_load  = 1'b1;
        end else if (!pause) begin
            case (state_q)
                INTERMISSION: if (tmr_zero) begin
                    speed_d   = cfg.speed;
                    life_d    = cfg.life;
                    size_d    = cfg.size;
                    deploys_d = '0;
                    state_d   = SPAWN;
                end
                SPAWN: if (tmr_zero && found) begin
                    deploy_d  = pick;
                    mask_d    = mask_q | pick;
                    deploys_d = deploys_q + 5'd1;
                    tmr_load  = 1'b1;
                    tmr_val   = 9'(SPAWN_GAP_MIN) + {1'b0, random_number & GAP_MASK};
                    if (deploys_d == size_q) state_d = ACTIVE;
                end
                ACTIVE: if (((mask_q & bird_alive) == '0) && (pend_q == '0)) begin
                    state_d = CLEARED;
                end
                CLEARED: begin
                    mask_d = '0;
                    wave_d = wave_q + WN_W'(1);
                    if (32'(wave_d) == NUM_WAVES) begin
                        state_d = WIN;
                    end else begin
                        state_d  = INTERMISSION;
                        tmr_load = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // Pending tracks alive edges even while paused; only the timeout is frozen.
        for (int unsigned i = 0; i < NUM_OF_BIRDS; i++) begin
            pend_d[i] = pend_q[i];
            if (start_game) pend_d[i] = 1'b0;
            else if (deploy_d[i]) pend_d[i] = 1'b1;
            else if (pend_q[i] && (bird_alive[i] || tmo_zero[i])) pend_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            wave_q    <= '0;
            speed_q   <= '0;
            life_q    <= '0;
            size_q    <= '0;
            deploys_q <= '0;
            mask_q    <= '0;
            pend_q    <= '0;
            deploy_q  <= '0;
            remain_q  <= '0;
        end else begin
            state_q   <= state_d;
            wave_q    <= wave_d;
            speed_q   <= speed_d;
            life_q    <= life_d;
            size_q    <= size_d;
            deploys_q <= deploys_d;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            deploy_q  <= deploy_d;
            remain_q  <= (size_q - deploys_q) + alive_cnt;
        end
    end

    frame_timer #(.W(9)) u_wave_timer (
        .clk        (clk),
        .resetN     (resetN),
        .tick_i     (tick),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    for (genvar g = 0; g < NUM_OF_BIRDS; g++) begin : g_tmo
        frame_timer #(.W(TMO_W)) u_tmo (
            .clk        (clk),
            .resetN     (resetN),
            .tick_i     (tick),
            .load_i     (deploy_d[g]),
            .load_val_i (TMO_W'(ALIVE_TIMEOUT)),
            .zero_o     (tmo_zero[g])
        );
    end

    assign deploy_bird     = deploy_q;
    assign bird_speed      = speed_q;
    assign bird_life       = life_q;
    assign wave_number     = wave_q;
    assign wave_active     = (state_q == SPAWN) || (state_q == ACTIVE);
    assign birds_remaining = remain_q;
    assign game_won        = (state_q == WIN);

endmodule

// File: tb/tb_bird_wave_ctrl.sv
// Randomized bench for bird_wave_ctrl against a frame-level behavioural model.
module tb_bird_wave_ctrl;

    localparam int NB           = 4;
    localparam int NW           = 8;
    localparam int BASE_B       = 1;
    localparam int BASE_L       = 2;
    localparam int SSTEP        = 2;
    localparam int IFRAMES      = 60;
    localparam int GMIN         = 16;
    localparam int GMASK        = 'h1F;
    localparam int TIMEOUT      = 4;
    localparam int FRAME_PERIOD = 4;

    localparam int PH_IDLE = 0, PH_INTER = 1, PH_SPAWN = 2, PH_ACTIVE = 3, PH_CLR = 4, PH_WIN = 5;

    logic          clk = 1'b0;
    logic          resetN;
    logic          startOfFrame;
    logic          start_game;
    logic          pause;
    logic [7:0]    random_number;
    logic [NB-1:0] bird_alive;
    logic [NB-1:0] deploy_bird;
    logic [1:0]    bird_speed;
    logic [3:0]    bird_life;
    logic [3:0]    wave_number;
    logic          wave_active;
    logic [4:0]    birds_remaining;
    logic          game_won;

    bird_wave_ctrl #(
        .NUM_OF_BIRDS(NB), .NUM_WAVES(NW), .BASE_BIRDS(BASE_B), .BASE_LIFE(BASE_L),
        .SPEED_STEP(SSTEP), .INTERMISSION_FRAMES(IFRAMES), .SPAWN_GAP_MIN(GMIN),
        .GAP_MASK(8'h1F), .ALIVE_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_game(start_game),
        .pause(pause), .random_number(random_number), .bird_alive(bird_alive),
        .deploy_bird(deploy_bird), .bird_speed(bird_speed), .bird_life(bird_life),
        .wave_number(wave_number), .wave_active(wave_active),
        .birds_remaining(birds_remaining), .game_won(game_won)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_n    = 0;

    // Reference model state
    int          m_phase, m_frames, m_wave, m_size, m_speed, m_life, m_launched, m_deploy, m_rem;
    bit [NB-1:0] m_used, m_wait;
    int          m_tmo[NB];

    // Bird environment
    int env_st[NB];
    int env_cnt[NB];
    bit busy0;
    int busy_frames;
    bit count_deploys;
    int g1_deploys;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_frames = 0; m_wave = 0; m_size = 0; m_speed = 0; m_life = 0;
        m_launched = 0; m_deploy = 0; m_rem = 0; m_used = '0; m_wait = '0;
        for (int i = 0; i < NB; i++) m_tmo[i] = 0;
    endtask

    task automatic model_step();
        int sel;
        int hits;
        bit tick_now;
        bit quiet;
        tick_now = startOfFrame && !pause;
        hits  = 0;
        quiet = (m_wait == '0);
        for (int i = 0; i < NB; i++)
            if (m_used[i] && bird_alive[i]) begin hits++; quiet = 0; end
        sel = -1;
        if (!start_game && !pause && m_phase == PH_SPAWN && m_frames == 0)
            for (int i = 0; i < NB; i++)
                if (sel < 0 && !bird_alive[i] && !m_used[i]) sel = i;
        for (int i = 0; i < NB; i++) begin
            if (start_game) m_wait[i] = 1'b0;
            else if (sel == i) m_wait[i] = 1'b1;
            else if (m_wait[i] && (bird_alive[i] || m_tmo[i] == 0)) m_wait[i] = 1'b0;
            if (sel == i) m_tmo[i] = TIMEOUT;
            else if (tick_now && m_tmo[i] > 0) m_tmo[i]--;
        end
        m_rem = m_size - m_launched + hits;
        if (start_game) begin
            m_phase = PH_INTER; m_frames = IFRAMES; m_wave = 0; m_used = '0;
            m_launched = 0; m_size = 0;
        end else if (!pause) begin
            case (m_phase)
                PH_INTER: if (m_frames == 0) begin
                    m_size     = min2(NB, BASE_B + m_wave);
                    m_speed    = min2(3, m_wave / SSTEP);
                    m_life     = min2(15, BASE_L + m_wave);
                    m_launched = 0;
                    m_phase    = PH_SPAWN;
                end else if (tick_now) m_frames--;
                PH_SPAWN: if (m_frames == 0) begin
                    if (sel >= 0) begin
                        m_used[sel] = 1'b1;
                        m_launched++;
                        m_frames = GMIN + (int'(random_number) & GMASK);
                        if (m_launched == m_size) m_phase = PH_ACTIVE;
                    end
                end else if (tick_now) m_frames--;
                PH_ACTIVE: if (quiet) m_phase = PH_CLR;
                PH_CLR: begin
                    m_used = '0;
                    m_wave++;
                    if (m_wave == NW) m_phase = PH_WIN;
                    else begin m_phase = PH_INTER; m_frames = IFRAMES; end
                end
                default: ;
            endcase
        end
        m_deploy = (sel >= 0) ? (1 << sel) : 0;
    endtask

    task automatic compare_outputs();
        check_eq("deploy", deploy_bird, m_deploy);
        check_eq("wave", wave_number, m_wave);
        check_eq("speed", bird_speed, m_speed);
        check_eq("life", bird_life, m_life);
        check_eq("active", wave_active, (m_phase == PH_SPAWN || m_phase == PH_ACTIVE));
        check_eq("won", game_won, (m_phase == PH_WIN));
        check_eq("remain", birds_remaining, m_rem);
        if (count_deploys && deploy_bird != '0) g1_deploys++;
    endtask

    task automatic env_step();
        logic [NB-1:0] a;
        a = '0;
        for (int i = 0; i < NB; i++) begin
            if (deploy_bird[i]) begin
                if ($urandom_range(0, 4) == 0) env_st[i] = 0;
                else begin env_st[i] = 1; env_cnt[i] = $urandom_range(0, 2); end
            end else if (startOfFrame) begin
                if (env_st[i] == 1) begin
                    if (env_cnt[i] == 0) begin env_st[i] = 2; env_cnt[i] = $urandom_range(2, 20); end
                    else env_cnt[i]--;
                end else if (env_st[i] == 2) begin
                    if (env_cnt[i] == 0) env_st[i] = 0;
                    else env_cnt[i]--;
                end
            end
            a[i] = (env_st[i] == 2);
        end
        if (busy0 && startOfFrame) begin
            if (busy_frames == 0) busy0 = 1'b0;
            else busy_frames--;
        end
        a[0] = a[0] | busy0;
        bird_alive = a;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
        env_step();
        cyc_n++;
        startOfFrame  = (cyc_n % FRAME_PERIOD == 0);
        random_number = 8'($urandom);
        start_game    = 1'b0;
    endtask

    task automatic run_game(input bit do_pause, input bit do_busy, input bit do_restart);
        bit paused_done  = 0;
        bit busy_done    = 0;
        bit restart_done = 0;
        int n = 0;
        while (m_phase != PH_WIN && n < 40000) begin
            cycle();
            n++;
            if (do_busy && !busy_done && m_phase == PH_INTER && m_wave == 2) begin
                busy_done = 1; busy0 = 1'b1; busy_frames = 120;
            end
            if (do_pause && !paused_done && m_phase == PH_SPAWN && m_wave == 3 && m_launched == 1) begin
                paused_done = 1;
                pause = 1'b1;
                for (int k = 0; k < 100 * FRAME_PERIOD; k++) cycle();
                pause = 1'b0;
            end
            if (do_restart && !restart_done && m_phase == PH_SPAWN && m_wave == 2 && m_launched == 2) begin
                restart_done = 1;
                start_game = 1'b1;
            end
        end
        check_eq("reached_win", game_won, 1);
    endtask

    initial begin
        int exp_deploys;
        resetN = 1'b0; startOfFrame = 1'b0; start_game = 1'b0; pause = 1'b0;
        random_number = '0; bird_alive = '0; busy0 = 1'b0; busy_frames = 0;
        count_deploys = 1'b0; g1_deploys = 0;
        for (int i = 0; i < NB; i++) begin env_st[i] = 0; env_cnt[i] = 0; end
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_deploy", deploy_bird, 0);
        check_eq("rst_wave", wave_number, 0);
        check_eq("rst_speed", bird_speed, 0);
        check_eq("rst_life", bird_life, 0);
        check_eq("rst_active", wave_active, 0);
        check_eq("rst_remain", birds_remaining, 0);
        check_eq("rst_won", game_won, 0);
        resetN = 1'b1;
        repeat (5) cycle();

        // Game 1: full run with a busy slot 0 in wave 2 and a long pause in wave 3
        count_deploys = 1'b1;
        start_game = 1'b1;
        run_game(1'b1, 1'b1, 1'b0);
        count_deploys = 1'b0;
        exp_deploys = 0;
        for (int w = 0; w < NW; w++) exp_deploys += min2(NB, BASE_B + w);
        check_eq("game1_deploys", g1_deploys, exp_deploys);
        check_eq("last_speed", bird_speed, 3);
        check_eq("last_life", bird_life, 9);
        check_eq("final_wave", wave_number, NW);
        repeat (20) cycle();
        check_eq("win_hold", game_won, 1);

        start_game = 1'b1;
        repeat (3) cycle();
        check_eq("restart_wave", wave_number, 0);
        check_eq("restart_won", game_won, 0);

        // Game 2: restart mid-wave 2, then play to the end
        run_game(1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
